// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing constants, pixel type and clear-FSM states for vga_frame_out
package vga_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int PIX_DIV = 2;

  localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FB_DEPTH = H_VIS * V_VIS;
  localparam int ADDR_W   = 19;

  typedef logic [5:0] pixel_t;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_e;

  // 2-bit colour field widened to 8 bits by replication
  function automatic logic [7:0] expand2(input logic [1:0] c);
    return {4{c}};
  endfunction

endpackage

// File: rtl/frame_buf_dp.sv
// rtl/frame_buf_dp.sv - simple dual-port frame buffer, one write port and one registered read port
module frame_buf_dp
  import vga_pkg::*;
#(
  parameter int DEPTH = FB_DEPTH
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  pixel_t            i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output pixel_t            o_rdata
);

  pixel_t r_mem [0:DEPTH-1];
  pixel_t r_rdata;

  // No reset on the array or read register so the block maps onto block RAM
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/vga_frame_out.sv
// rtl/vga_frame_out.sv - frame buffer with placer write port, clear engine and 640x480@60 VGA scan-out
module vga_frame_out
  import vga_pkg::*;
#(
  parameter int P_H_VIS   = H_VIS,
  parameter int P_H_FP    = H_FP,
  parameter int P_H_SYNC  = H_SYNC,
  parameter int P_H_BP    = H_BP,
  parameter int P_V_VIS   = V_VIS,
  parameter int P_V_FP    = V_FP,
  parameter int P_V_SYNC  = V_SYNC,
  parameter int P_V_BP    = V_BP,
  parameter int P_PIX_DIV = PIX_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [5:0]        wdata,
  input  logic              we,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              frame_tick,
  output logic              VGA_CLK,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLANK_N,
  output logic [7:0]        VGA_R,
  output logic [7:0]        VGA_G,
  output logic [7:0]        VGA_B
);

  localparam int H_TOT_L = P_H_VIS + P_H_FP + P_H_SYNC + P_H_BP;
  localparam int V_TOT_L = P_V_VIS + P_V_FP + P_V_SYNC + P_V_BP;
  localparam int DEPTH_L = P_H_VIS * P_V_VIS;
  localparam int DIV_W   = (P_PIX_DIV > 1) ? $clog2(P_PIX_DIV) : 1;

  localparam logic [9:0]        H_LAST   = 10'(H_TOT_L - 1);
  localparam logic [9:0]        V_LAST   = 10'(V_TOT_L - 1);
  localparam logic [9:0]        H_VIS_W  = 10'(P_H_VIS);
  localparam logic [9:0]        V_VIS_W  = 10'(P_V_VIS);
  localparam logic [9:0]        HS_BEG   = 10'(P_H_VIS + P_H_FP);
  localparam logic [9:0]        HS_END   = 10'(P_H_VIS + P_H_FP + P_H_SYNC);
  localparam logic [9:0]        VS_BEG   = 10'(P_V_VIS + P_V_FP);
  localparam logic [9:0]        VS_END   = 10'(P_V_VIS + P_V_FP + P_V_SYNC);
  localparam logic [ADDR_W-1:0] DEPTH_W  = ADDR_W'(DEPTH_L);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH_L - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(P_PIX_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(P_PIX_DIV / 2);

  logic [DIV_W-1:0]  r_div;
  logic              r_vga_clk;
  logic [9:0]        r_h_cnt, r_v_cnt;
  logic [ADDR_W-1:0] r_raddr;
  logic              r_vis1, r_hs1, r_vs1;
  logic              r_hs, r_vs, r_blank_n, r_frame_tick;
  logic [7:0]        r_r, r_g, r_b;
  clr_state_e        r_clr_state, w_clr_state_nx;
  logic [ADDR_W-1:0] r_clr_addr, w_clr_addr_nx;

  logic              w_pix_en, w_vis, w_hs_raw, w_vs_raw, w_h_last, w_v_last;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_waddr;
  pixel_t            w_ram_wdata, w_rdata;

  assign w_pix_en = (r_div == DIV_LAST);
  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);
  assign w_vis    = (r_h_cnt < H_VIS_W) && (r_v_cnt < V_VIS_W);
  assign w_hs_raw = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
  assign w_vs_raw = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));

  // VGA_CLK rises one clk after the outputs change, i.e. mid-pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div     <= '0;
      r_vga_clk <= 1'b0;
    end else begin
      r_div     <= w_pix_en ? '0 : r_div + DIV_W'(1);
      r_vga_clk <= (r_div < DIV_HALF);
    end
  end

  // Stage 0: scan position and the matching linear read address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_raddr <= '0;
    end else if (w_pix_en) begin
      r_h_cnt <= w_h_last ? '0 : r_h_cnt + 10'd1;
      if (w_h_last) r_v_cnt <= w_v_last ? '0 : r_v_cnt + 10'd1;
      if (w_h_last && w_v_last) r_raddr <= '0;
      else if (w_vis)           r_raddr <= r_raddr + ADDR_W'(1);
    end
  end

  // Stages 1 and 2: timing flags ride alongside the RAM read so syncs and data stay aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vis1       <= 1'b0;
      r_hs1        <= 1'b1;
      r_vs1        <= 1'b1;
      r_blank_n    <= 1'b0;
      r_hs         <= 1'b1;
      r_vs         <= 1'b1;
      r_r          <= '0;
      r_g          <= '0;
      r_b          <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_pix_en && (r_h_cnt == 10'd0) && (r_v_cnt == V_VIS_W);
      if (w_pix_en) begin
        r_vis1    <= w_vis;
        r_hs1     <= w_hs_raw;
        r_vs1     <= w_vs_raw;
        r_blank_n <= r_vis1;
        r_hs      <= r_hs1;
        r_vs      <= r_vs1;
        r_r       <= r_vis1 ? expand2(w_rdata[5:4]) : 8'd0;
        r_g       <= r_vis1 ? expand2(w_rdata[3:2]) : 8'd0;
        r_b       <= r_vis1 ? expand2(w_rdata[1:0]) : 8'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_state <= CLR_IDLE;
      r_clr_addr  <= '0;
    end else begin
      r_clr_state <= w_clr_state_nx;
      r_clr_addr  <= w_clr_addr_nx;
    end
  end

  always_comb begin
    w_clr_state_nx = r_clr_state;
    w_clr_addr_nx  = r_clr_addr;
    case (r_clr_state)
      CLR_IDLE: begin
        if (clr_req) begin
          w_clr_state_nx = CLR_CLEAR;
          w_clr_addr_nx  = '0;
        end
      end
      CLR_CLEAR: begin
        if (r_clr_addr == CLR_LAST) begin
          w_clr_state_nx = CLR_IDLE;
          w_clr_addr_nx  = '0;
        end else begin
          w_clr_addr_nx = r_clr_addr + ADDR_W'(1);
        end
      end
      default: w_clr_state_nx = CLR_IDLE;
    endcase
  end

  // Clear owns the write port while busy; out-of-range placer writes are discarded
  always_comb begin
    w_ram_we    = we && (waddr < DEPTH_W);
    w_ram_waddr = waddr;
    w_ram_wdata = wdata;
    if (r_clr_state == CLR_CLEAR) begin
      w_ram_we    = 1'b1;
      w_ram_waddr = r_clr_addr;
      w_ram_wdata = '0;
    end
  end

  frame_buf_dp #(
    .DEPTH (DEPTH_L)
  ) u_fb (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_re    (w_pix_en && w_vis),
    .i_raddr (r_raddr),
    .o_rdata (w_rdata)
  );

  assign clr_busy    = (r_clr_state == CLR_CLEAR);
  assign frame_tick  = r_frame_tick;
  assign VGA_CLK     = r_vga_clk;
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_BLANK_N = r_blank_n;
  assign VGA_R       = r_r;
  assign VGA_G       = r_g;
  assign VGA_B       = r_b;

endmodule

// File: tb/tb_vga_frame_out.sv
// tb/tb_vga_frame_out.sv - directed bench: full-size instance for line timing and pixels, small instance for frames and clear
module tb_vga_frame_out;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_n;

  logic [18:0] f_waddr, s_waddr;
  logic [5:0]  f_wdata, s_wdata;
  logic        f_we, s_we, f_clr_req, s_clr_req;
  logic        f_busy, f_tick, f_vclk, f_hs, f_vs, f_blank_n;
  logic        s_busy, s_tick, s_vclk, s_hs, s_vs, s_blank_n;
  logic [7:0]  f_r, f_g, f_b, s_r, s_g, s_b;

  vga_frame_out u_full (
    .clk(clk), .rst_n(rst_n), .waddr(f_waddr), .wdata(f_wdata), .we(f_we),
    .clr_req(f_clr_req), .clr_busy(f_busy), .frame_tick(f_tick), .VGA_CLK(f_vclk),
    .VGA_HS(f_hs), .VGA_VS(f_vs), .VGA_BLANK_N(f_blank_n),
    .VGA_R(f_r), .VGA_G(f_g), .VGA_B(f_b)
  );

  // 24x13-pixel frame (16x8 visible): 624 clk per frame, 128-entry buffer
  vga_frame_out #(
    .P_H_VIS(16), .P_H_FP(2), .P_H_SYNC(4), .P_H_BP(2),
    .P_V_VIS(8), .P_V_FP(2), .P_V_SYNC(1), .P_V_BP(2), .P_PIX_DIV(2)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .waddr(s_waddr), .wdata(s_wdata), .we(s_we),
    .clr_req(s_clr_req), .clr_busy(s_busy), .frame_tick(s_tick), .VGA_CLK(s_vclk),
    .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_blank_n),
    .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b)
  );

  int cyc;
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
  endtask

  // Output sampled at cyc k shows pixel (k-4)/2; odd k is the mid-pixel sample
  logic [23:0] cap [0:1599];
  int   f_brgb_err = 0, f_vclk_err = 0, f_tick_cnt = 0, f_bl_cnt = 0;
  int   f_hs_fall0 = -1, f_hs_fall1 = -1, f_hs_rise = -1, f_bl_rise = -1, f_bl_fall = -1;
  logic f_prev_hs = 1'b1, f_prev_bl = 1'b0;

  always @(negedge clk) begin
    if (rst_n && cyc >= 1) begin
      if (cyc >= 5 && (cyc % 2) == 1 && (cyc - 5) / 2 < 1600) cap[(cyc - 5) / 2] <= {f_r, f_g, f_b};
      if (!f_blank_n && {f_r, f_g, f_b} != 24'h0) f_brgb_err <= f_brgb_err + 1;
      if (f_vclk != ((cyc % 2) == 1)) f_vclk_err <= f_vclk_err + 1;
      if (f_tick) f_tick_cnt <= f_tick_cnt + 1;
      if (cyc < 1600 && f_blank_n) f_bl_cnt <= f_bl_cnt + 1;
      f_prev_hs <= f_hs;
      f_prev_bl <= f_blank_n;
      if (f_prev_hs && !f_hs) begin
        if (f_hs_fall0 < 0)      f_hs_fall0 <= cyc;
        else if (f_hs_fall1 < 0) f_hs_fall1 <= cyc;
      end
      if (!f_prev_hs && f_hs && f_hs_rise < 0) f_hs_rise <= cyc;
      if (!f_prev_bl && f_blank_n && f_bl_rise < 0) f_bl_rise <= cyc;
      if (f_prev_bl && !f_blank_n && f_bl_fall < 0) f_bl_fall <= cyc;
    end
  end

  int s_n, s_p, s_h, s_v, s_fr;
  logic s_vis_m, s_hs_m, s_vs_m, s_tick_m;
  always_comb begin
    s_n  = (cyc - 4) / 2;
    s_fr = s_n / 312;
    s_p  = s_n % 312;
    s_h  = s_p % 24;
    s_v  = s_p / 24;
    s_vis_m  = (s_h < 16) && (s_v < 8);
    s_hs_m   = !(s_h >= 18 && s_h < 22);
    s_vs_m   = !(s_v == 10);
    s_tick_m = (cyc >= 386) && ((cyc - 386) % 624 == 0);
  end

  int s_sync_err = 0, s_pix_err = 0, s_pix_seen = 0, s_tick_err = 0, s_tick_cnt = 0;
  int s_busy_cnt = 0, s_vs_low = 0, s_vs_fall = -1, s_brgb_err = 0;
  logic [23:0] s_px5 = 24'hDEAD00;
  logic s_prev_vs = 1'b1;

  always @(negedge clk) begin
    if (rst_n && cyc >= 1) begin
      if (s_busy) s_busy_cnt <= s_busy_cnt + 1;
      if (s_tick) s_tick_cnt <= s_tick_cnt + 1;
      if (s_tick != s_tick_m) s_tick_err <= s_tick_err + 1;
      if (!s_blank_n && {s_r, s_g, s_b} != 24'h0) s_brgb_err <= s_brgb_err + 1;
      if (cyc < 628 && !s_vs) s_vs_low <= s_vs_low + 1;
      s_prev_vs <= s_vs;
      if (s_prev_vs && !s_vs && s_vs_fall < 0) s_vs_fall <= cyc;
      if (cyc == 1263) s_px5 <= {s_r, s_g, s_b};
      if (cyc >= 4) begin
        if (s_blank_n != s_vis_m || s_hs != s_hs_m || s_vs != s_vs_m) s_sync_err <= s_sync_err + 1;
        if ((cyc % 2) == 1 && s_vis_m && (s_fr == 0 || s_fr == 2)) begin
          s_pix_seen <= s_pix_seen + 1;
          if ({s_r, s_g, s_b} != ((s_fr == 0) ? 24'hFFFFFF : 24'h000000)) s_pix_err <= s_pix_err + 1;
        end
      end
    end
  end

  typedef struct {
    logic [18:0] waddr;
    logic [5:0]  wdata;
    int          n;
    logic [23:0] exp_rgb;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{19'd0,      6'h3F,      0,    24'hFFFFFF};
    vecs[1] = '{19'd1,      6'h00,      1,    24'h000000};
    vecs[2] = '{19'd2,      6'b000100,  2,    24'h005500};
    vecs[3] = '{19'd639,    6'b001000,  639,  24'h00AA00};
    vecs[4] = '{19'd640,    6'b000010,  800,  24'h0000AA};
    vecs[5] = '{19'd641,    6'b110000,  801,  24'hFF0000};
    vecs[6] = '{19'd643,    6'b100111,  803,  24'hAA55FF};
    vecs[7] = '{19'd1279,   6'b011011,  1439, 24'h55AAFF};
    vecs[8] = '{19'd307200, 6'h3F,      1,    24'h000000};
    vecs[9] = '{19'd524287, 6'h3F,      1,    24'h000000};

    rst_n = 1'b0;
    f_we = 1'b0; f_waddr = '0; f_wdata = '0; f_clr_req = 1'b0;
    s_we = 1'b0; s_waddr = '0; s_wdata = '0; s_clr_req = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_hs",     f_hs,      1);
    check("rst_vs",     f_vs,      1);
    check("rst_blank_n", f_blank_n, 0);
    check("rst_rgb",    {f_r, f_g, f_b}, 0);
    check("rst_busy",   f_busy,    0);
    check("rst_tick",   f_tick,    0);
    check("rst_vga_clk", f_vclk,   0);

    // Buffer has no reset, so preload both instances while the scan is held
    for (int i = 0; i < 10; i++) begin
      f_we = 1'b1; f_waddr = vecs[i].waddr; f_wdata = vecs[i].wdata;
      @(negedge clk);
    end
    f_we = 1'b0;
    for (int i = 0; i < 128; i++) begin
      s_we = 1'b1; s_waddr = 19'(i); s_wdata = 6'h3F;
      @(negedge clk);
    end
    s_we = 1'b0;
    rst_n = 1'b1;

    while (cyc < 700) @(negedge clk);
    s_clr_req = 1'b1;
    @(negedge clk);
    s_clr_req = 1'b0;
    while (cyc < 764) @(negedge clk);
    s_we = 1'b1; s_waddr = 19'd5; s_wdata = 6'h3F;
    @(negedge clk);
    s_we = 1'b0;
    while (cyc < 780) @(negedge clk);
    s_clr_req = 1'b1;
    @(negedge clk);
    s_clr_req = 1'b0;
    while (cyc < 3300) @(negedge clk);

    for (int i = 0; i < 10; i++)
      check($sformatf("pix_vec%0d_addr%0d", i, vecs[i].waddr), cap[vecs[i].n], vecs[i].exp_rgb);

    check("hs_first_fall",  f_hs_fall0, 1316);
    check("hs_first_rise",  f_hs_rise,  1508);
    check("hs_second_fall", f_hs_fall1, 2916);
    check("blank_first_rise", f_bl_rise, 4);
    check("blank_first_fall", f_bl_fall, 1284);
    check("blank_high_line0", f_bl_cnt, 1280);
    check("full_rgb_in_blank", f_brgb_err, 0);
    check("vga_clk_phase",  f_vclk_err, 0);
    check("full_no_tick",   f_tick_cnt, 0);

    check("small_sync_model", s_sync_err, 0);
    check("small_pix_seen",   s_pix_seen, 256);
    check("small_pix_err",    s_pix_err,  0);
    check("small_tick_model", s_tick_err, 0);
    check("small_tick_count", s_tick_cnt, 5);
    check("small_busy_clks",  s_busy_cnt, 128);
    check("small_vs_fall",    s_vs_fall,  484);
    check("small_vs_low",     s_vs_low,   48);
    check("small_px5_after_clear", s_px5, 0);
    check("small_rgb_in_blank", s_brgb_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_frame_out.md
Name: vga_frame_out

Overview:
- Downstream consumer of the 6-bit bitmap placer. Holds the 640x480 frame buffer, accepts the placer's write stream (waddr/wdata/we), and scans the buffer out as 640x480@60 VGA.
- Also provides a hardware clear-screen engine and a once-per-frame tick, so firmware can schedule placements during vertical blank.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIX_DIV, 2, clk cycles per pixel (50 MHz clk gives 25 MHz pixels)

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  asynchronous active-low reset
- waddr  in  19  placer write address, linear y*640+x
- wdata  in  6  placer pixel {R[1:0],G[1:0],B[1:0]}
- we  in  1  placer write enable
- clr_req  in  1  single-cycle pulse: clear entire buffer to 0
- clr_busy  out  1  high while clear in progress
- frame_tick  out  1  one-clk pulse at start of vertical blank
- VGA_CLK  out  1  pixel clock (clk/PIX_DIV, registered)
- VGA_HS  out  1  hsync, active low
- VGA_VS  out  1  vsync, active low
- VGA_BLANK_N  out  1  high during the visible region
- VGA_R, VGA_G, VGA_B  out  8 each  colour; each 2-bit field replicated 4x

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - all counters 0; clear FSM IDLE
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, RGB=0
  - clr_busy=0, frame_tick=0, VGA_CLK=0
  - frame buffer contents are not reset.
- pix_en: one-clk strobe every PIX_DIV clks. VGA_CLK toggles so that its rising edge falls mid-pixel.
- Scan counters (advance only on pix_en):
  - h_cnt 0..799 wraps to 0, and on wrap increments v_cnt.
  - v_cnt 0..524 wraps to 0.
- Read address: incremental counter, no multiplier.
  - Reset to 0 when h_cnt=0 and v_cnt=0.
  - +1 on each pix_en where h<640 and v<480.
- Timing regions:
  - hs_raw low for h in [656,751].
  - vs_raw low for v in [490,491].
  - vis = h<640 && v<480.
- Pipeline, counted in pixel periods:
  - stage0: counters and raddr.
  - stage1: RAM registered read; hs/vs/vis delayed to match.
  - stage2: output registers.
  - Total latency 2 pixel periods, identical for data and syncs.
  - RGB forced to 0 when the delayed vis=0.
- frame_tick: one-clk pulse on the pix_en where h_cnt=0 and v_cnt=480.
- Write port:
  - Writes to the buffer when we=1 and waddr<307200.
  - waddr>=307200 is dropped, with no aliasing.
  - Write-to-read latency is not guaranteed in the same pixel period; a read at the same address returns old data.
- Clear FSM:
  - IDLE: clr_req -> CLEAR, clr_addr=0, clr_busy=1 next clk.
  - CLEAR: writes 0 to clr_addr every clk. At clr_addr=307199 -> IDLE, clr_busy=0 next clk.
  - clr_busy is high for exactly 307200 clks.
  - clr_req while in CLEAR is ignored.
  - Placer writes during CLEAR are dropped; clear has priority.
  - Scan-out continues unaffected during a clear.
- Reset mid-clear: returns to IDLE immediately; the buffer is left partially cleared.

Decomposition:
- vga_pkg holds:
  - timing localparams and derived totals H_TOT=800, V_TOT=525
  - FB_DEPTH=307200
  - typedef pixel_t (logic[5:0])
  - clear-FSM state enum
- Sub-module frame_buf_dp: simple dual-port RAM, 1 write / 1 registered read, depth FB_DEPTH, 6-bit data, inferred M10K.

Test Plan:
- Reset release:
  - VGA_HS low pulse is 192 clk wide with period 1600 clk.
  - VGA_VS low for 3200 clk with period 840000 clk.
  - BLANK_N high 1280 clk per visible line.
- we=1, waddr=0, wdata=6'h3F:
  - first visible pixel of the next frame has R=G=B=8'hFF.
  - waddr=641, wdata=6'b110000: pixel (1,1) has R=8'hFF, G=0, B=0.
- Fill the buffer with 6'h3F:
  - RGB=0 whenever BLANK_N=0.
  - RGB and syncs align exactly, giving the 2-pixel latency.
- clr_req pulse after fill:
  - clr_busy high exactly 307200 clk.
  - we=1, waddr=5, wdata=3F mid-clear is dropped.
  - second clr_req is ignored.
  - next frame is all 0.
- we=1, waddr=307200, wdata=3F:
  - no change at address 0 or anywhere visible.
- frame_tick: exactly one 1-clk pulse per 840000 clk, coincident with the first non-visible line.
